// File: rtl/pll_profile_scheduler.sv
// Round-robin scheduler sharing one PLL reconfiguration engine among NUM_REQ requesters.
// Optional PLL_LOCK_SYNC_EN: double-flop synchronizer on the locked input.
`timescale 1ns/1ps
module pll_profile_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned TMR_W         = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_profile,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     nack,
  output logic [NUM_REQ-1:0]     grant,
  input  logic                   busy,
  input  logic                   locked,
  output logic                   want_to_reconfig,
  output logic [2:0]             intended_rom,
  output logic                   main_reset_rom_address,
  output logic [2:0]             current_profile,
  output logic                   profile_valid,
  output logic [2:0]             sched_state
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RTY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    RST_ADDR  = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_LOCK = 3'd5,
    RESP      = 3'd6,
    FAIL      = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [2:0]         intended_rom_q, intended_rom_d;
  logic [2:0]         current_profile_q, current_profile_d;
  logic               profile_valid_q, profile_valid_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] nack_q, nack_d;
  logic               want_q, want_d;
  logic               mrra_q, mrra_d;
  logic               lock_use;

`ifdef PLL_LOCK_SYNC_EN
  logic lock_s1_q, lock_s2_q;

  // Two-stage synchronizer for an asynchronous PLL lock indicator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  assign lock_use = lock_s2_q;
`else
  assign lock_use = locked;
`endif

  // Unpack the per-requester profile slices.
  logic [2:0] prof_arr [NUM_REQ];
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      prof_arr[k] = req_profile[3*k +: 3];
    end
  end

  // First asserted request at or after the round-robin pointer.
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand_idx;
  int unsigned      arb_cand;
  logic [2:0]       arb_profile;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_cand = 32'(ptr_q) + k;
      if (arb_cand >= NUM_REQ) arb_cand = arb_cand - NUM_REQ;
      cand_idx = IDX_W'(arb_cand);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
    arb_profile = prof_arr[arb_idx];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    winner_d          = winner_q;
    timer_d           = '0;
    retry_d           = retry_q;
    intended_rom_d    = intended_rom_q;
    current_profile_d = current_profile_q;
    profile_valid_d   = profile_valid_q;
    grant_d           = grant_q;
    ack_d             = '0;
    nack_d            = '0;
    want_d            = 1'b0;
    mrra_d            = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (arb_found) begin
          winner_d       = arb_idx;
          intended_rom_d = arb_profile;
          grant_d        = NUM_REQ'(1) << arb_idx;
          ptr_d          = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
          if (profile_valid_q && (arb_profile == current_profile_q) && lock_use)
            state_d = RESP;
          else
            state_d = RST_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RST_ADDR: state_d = START;
      START: begin
        if (busy)
          state_d = WAIT_BUSY;
        else if (timer_q == TMR_W'(START_TIMEOUT - 1))
          state_d = FAIL;
        else
          timer_d = timer_q + TMR_W'(1);
      end
      WAIT_BUSY: begin
        if (!busy) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the final timeout cycle still wins.
        if (lock_use)
          state_d = RESP;
        else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1))
          state_d = FAIL;
        else
          timer_d = timer_q + TMR_W'(1);
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
        retry_d = '0;
      end
      FAIL: begin
        if (32'(retry_q) < MAX_RETRY) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = RST_ADDR;
        end else begin
          retry_d = '0;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry actions so the pulses line up with the state they belong to.
    if (state_d == RESP && state_q != RESP) begin
      ack_d             = NUM_REQ'(1) << winner_d;
      current_profile_d = intended_rom_d;
      profile_valid_d   = 1'b1;
    end
    if (state_d == FAIL && state_q != FAIL) begin
      profile_valid_d = 1'b0;
      if (32'(retry_q) >= MAX_RETRY) nack_d = NUM_REQ'(1) << winner_q;
    end
    mrra_d = (state_d == RST_ADDR);
    want_d = (state_d == START);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      ptr_q             <= '0;
      winner_q          <= '0;
      timer_q           <= '0;
      retry_q           <= '0;
      intended_rom_q    <= '0;
      current_profile_q <= '0;
      profile_valid_q   <= 1'b0;
      grant_q           <= '0;
      ack_q             <= '0;
      nack_q            <= '0;
      want_q            <= 1'b0;
      mrra_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      winner_q          <= winner_d;
      timer_q           <= timer_d;
      retry_q           <= retry_d;
      intended_rom_q    <= intended_rom_d;
      current_profile_q <= current_profile_d;
      profile_valid_q   <= profile_valid_d;
      grant_q           <= grant_d;
      ack_q             <= ack_d;
      nack_q            <= nack_d;
      want_q            <= want_d;
      mrra_q            <= mrra_d;
    end
  end

  assign ack                    = ack_q;
  assign nack                   = nack_q;
  assign grant                  = grant_q;
  assign want_to_reconfig       = want_q;
  assign main_reset_rom_address = mrra_q;
  assign intended_rom           = intended_rom_q;
  assign current_profile        = current_profile_q;
  assign profile_valid          = profile_valid_q;
  assign sched_state            = state_q;

endmodule

// File: tb/tb_pll_profile_scheduler.sv
// Directed bench for pll_profile_scheduler with a behavioural reconfig engine.
`timescale 1ns/1ps
module tb_pll_profile_scheduler;

  localparam int NREQ = 4;
  localparam int LT   = 200;
  localparam int ST   = 16;
  localparam int MR   = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [3*NREQ-1:0] req_profile = '0;
  logic [NREQ-1:0] ack, nack, grant;
  logic            busy, locked;
  logic            want_to_reconfig, main_reset_rom_address, profile_valid;
  logic [2:0]      intended_rom, current_profile, sched_state;

  pll_profile_scheduler #(
    .NUM_REQ(NREQ), .LOCK_TIMEOUT(LT), .START_TIMEOUT(ST), .MAX_RETRY(MR), .TMR_W(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_profile(req_profile),
    .ack(ack), .nack(nack), .grant(grant), .busy(busy), .locked(locked),
    .want_to_reconfig(want_to_reconfig), .intended_rom(intended_rom),
    .main_reset_rom_address(main_reset_rom_address), .current_profile(current_profile),
    .profile_valid(profile_valid), .sched_state(sched_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Engine model: 0 = normal, 1 = never locks, 2 = never goes busy.
  int eng_mode = 0;
  int eng_phase = 0;
  int eng_cnt = 0;

  initial begin
    busy = 1'b0;
    locked = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        eng_phase = 0; busy = 1'b0; locked = 1'b0;
      end else begin
        case (eng_phase)
          0: if (want_to_reconfig && eng_mode != 2) begin
               locked = 1'b0; eng_phase = 1; eng_cnt = 0;
             end
          1: begin eng_cnt++; if (eng_cnt == 2) begin busy = 1'b1; eng_phase = 2; eng_cnt = 0; end end
          2: begin eng_cnt++; if (eng_cnt == 20) begin busy = 1'b0; eng_phase = 3; eng_cnt = 0; end end
          default: begin
            if (eng_mode != 0) eng_phase = 0;
            else begin
              eng_cnt++;
              if (eng_cnt == 100) begin locked = 1'b1; eng_phase = 0; end
            end
          end
        endcase
      end
    end
  end

  // Passive monitor: event counters and invariant violations.
  int n_mrra = 0, n_want_rise = 0, n_want_cyc = 0, n_wl_cyc = 0, n_viol = 0;
  int n_ack[NREQ] = '{default: 0};
  int n_nack[NREQ] = '{default: 0};
  int grant_log[$];
  logic want_prev = 1'b0;
  logic [NREQ-1:0] grant_prev = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (main_reset_rom_address) n_mrra++;
      if (want_to_reconfig) n_want_cyc++;
      if (want_to_reconfig && !want_prev) n_want_rise++;
      if (sched_state == 3'd5) n_wl_cyc++;
      if (want_to_reconfig && main_reset_rom_address) n_viol++;
      if ($countones(grant) > 1 || $countones(ack) > 1 || $countones(nack) > 1) n_viol++;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) n_ack[i]++;
        if (nack[i]) n_nack[i]++;
        if (grant[i] && grant_prev == '0) grant_log.push_back(i);
      end
      want_prev  = want_to_reconfig;
      grant_prev = grant;
    end
  end

  // Wait for any ack/nack, drop that requester's req, report who and which.
  task automatic wait_any(input int budget, output int idx, output bit is_ack, output int cycles);
    idx = -1; is_ack = 1'b0; cycles = 0;
    while (cycles < budget && idx < 0) begin
      @(negedge clock);
      cycles++;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] || nack[i]) begin
          idx = i; is_ack = ack[i]; req[i] = 1'b0;
        end
      end
    end
    if (idx < 0) check("resp_timeout", 32'(cycles), 32'(budget + 1));
  endtask

  int idx, cyc, gl0, s_mrra, s_rise, s_wcyc, s_wl, s_ack, s_nack;
  bit is_ack;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_outs", 32'({ack, nack, grant, want_to_reconfig, main_reset_rom_address,
                           intended_rom, current_profile, profile_valid, sched_state}), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_state", 32'(sched_state), 32'd0);

    // Single request, profile 3
    s_mrra = n_mrra; s_rise = n_want_rise;
    req_profile[2:0] = 3'd3; req = 4'b0001;
    wait_any(1000, idx, is_ack, cyc);
    check("t1_idx", 32'(idx), 32'd0);
    check("t1_ack", 32'(is_ack), 32'd1);
    check("t1_rom", 32'(intended_rom), 32'd3);
    repeat (2) @(negedge clock);
    check("t1_mrra", 32'(n_mrra - s_mrra), 32'd1);
    check("t1_want", 32'(n_want_rise - s_rise), 32'd1);
    check("t1_cur", 32'(current_profile), 32'd3);
    check("t1_valid", 32'(profile_valid), 32'd1);
    check("t1_ackcnt", 32'(n_ack[0]), 32'd1);
    check("t1_state", 32'(sched_state), 32'd0);

    // Same profile again while locked: skip reconfig
    s_mrra = n_mrra; s_rise = n_want_rise;
    req = 4'b0001;
    wait_any(50, idx, is_ack, cyc);
    check("t3_ack", 32'(is_ack), 32'd1);
    check("t3_lat", 32'(cyc <= 2), 32'd1);
    repeat (2) @(negedge clock);
    check("t3_want", 32'(n_want_rise - s_rise), 32'd0);
    check("t3_mrra", 32'(n_mrra - s_mrra), 32'd0);
    check("t3_cur", 32'(current_profile), 32'd3);

    // Round robin between requesters 1 and 3
    gl0 = grant_log.size();
    req_profile[5:3] = 3'd5; req_profile[11:9] = 3'd6; req = 4'b1010;
    wait_any(1000, idx, is_ack, cyc);
    check("t2_first", 32'(idx), 32'd1);
    check("t2_cur5", 32'(current_profile), 32'd5);
    wait_any(1000, idx, is_ack, cyc);
    check("t2_second", 32'(idx), 32'd3);
    check("t2_cur6", 32'(current_profile), 32'd6);
    req = 4'b1010;
    wait_any(1000, idx, is_ack, cyc);
    check("t2_third", 32'(idx), 32'd1);
    wait_any(1000, idx, is_ack, cyc);
    check("t2_fourth", 32'(idx), 32'd3);
    check("t2_loglen", 32'(grant_log.size() - gl0), 32'd4);
    if (grant_log.size() - gl0 == 4) begin
      check("t2_log", 32'({grant_log[gl0][3:0], grant_log[gl0+1][3:0],
                           grant_log[gl0+2][3:0], grant_log[gl0+3][3:0]}), 32'h1313);
    end

    // Lock never arrives: three attempts then nack
    repeat (2) @(negedge clock);
    eng_mode = 1;
    s_mrra = n_mrra; s_rise = n_want_rise; s_wl = n_wl_cyc; s_ack = n_ack[2];
    req_profile[8:6] = 3'd1; req = 4'b0100;
    wait_any(3000, idx, is_ack, cyc);
    check("t4_idx", 32'(idx), 32'd2);
    check("t4_nack", 32'(is_ack), 32'd0);
    check("t4_valid", 32'(profile_valid), 32'd0);
    repeat (2) @(negedge clock);
    check("t4_attempts", 32'(n_want_rise - s_rise), 32'd3);
    check("t4_mrra", 32'(n_mrra - s_mrra), 32'd3);
    check("t4_wlcyc", 32'(n_wl_cyc - s_wl), 32'(3 * LT));
    check("t4_nackcnt", 32'(n_nack[2]), 32'd1);
    check("t4_noack", 32'(n_ack[2] - s_ack), 32'd0);

    // Busy never rises: start timeout each attempt
    eng_mode = 2;
    s_mrra = n_mrra; s_wcyc = n_want_cyc;
    req_profile[11:9] = 3'd2; req = 4'b1000;
    wait_any(500, idx, is_ack, cyc);
    check("t5_idx", 32'(idx), 32'd3);
    check("t5_nack", 32'(is_ack), 32'd0);
    repeat (2) @(negedge clock);
    check("t5_wantcyc", 32'(n_want_cyc - s_wcyc), 32'(3 * ST));
    check("t5_mrra", 32'(n_mrra - s_mrra), 32'd3);
    check("t5_nackcnt", 32'(n_nack[3]), 32'd1);

    // Reset during WAIT_LOCK
    eng_mode = 0;
    req_profile[2:0] = 3'd4; req = 4'b0001;
    cyc = 0;
    while (sched_state != 3'd5 && cyc < 500) begin @(negedge clock); cyc++; end
    check("t6_reach_wl", 32'(sched_state), 32'd5);
    repeat (10) @(negedge clock);
    s_ack = n_ack[0]; s_nack = n_nack[0];
    reset_n = 1'b0;
    #1;
    check("t6_rst_outs", 32'({ack, nack, grant, want_to_reconfig, main_reset_rom_address,
                              intended_rom, current_profile, profile_valid, sched_state}), 32'd0);
    req = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("t6_idle", 32'(sched_state), 32'd0);
    check("t6_noresp", 32'((n_ack[0] - s_ack) + (n_nack[0] - s_nack)), 32'd0);
    req_profile[5:3] = 3'd7; req = 4'b0010;
    wait_any(1000, idx, is_ack, cyc);
    check("t6_idx", 32'(idx), 32'd1);
    check("t6_ack", 32'(is_ack), 32'd1);
    check("t6_cur", 32'(current_profile), 32'd7);
    check("t6_valid", 32'(profile_valid), 32'd1);

    check("invariants", 32'(n_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
